// File: rtl/vld_rdy_fifo.sv
// rtl/vld_rdy_fifo.sv - multi-entry valid/ready FIFO; optional zero-latency bypass via VLD_RDY_FIFO_BYPASS_EN
module vld_rdy_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vld_i,
  output logic          rdy_o,
  input  logic [DW-1:0] data_i,
  output logic          vld_o,
  input  logic          rdy_i,
  output logic [DW-1:0] data_o,
  output logic [AW:0]   cnt_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] head;
  logic          empty, full, push, pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  assign rdy_o   = ~full;
  assign full_o  = full;
  assign empty_o = empty;
  assign cnt_o   = wr_ptr_q - rd_ptr_q;

`ifdef VLD_RDY_FIFO_BYPASS_EN
  logic bypass;
  assign bypass = empty & vld_i;
  assign vld_o  = ~empty | vld_i;
  assign data_o = bypass ? data_i : head;
  // A word taken straight through never touches storage.
  assign push   = vld_i & rdy_o & ~(bypass & rdy_i);
  assign pop    = ~empty & rdy_i;
`else
  assign vld_o  = ~empty;
  assign data_o = head;
  assign push   = vld_i & rdy_o;
  assign pop    = vld_o & rdy_i;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: tb/tb_vld_rdy_fifo.sv
// tb/tb_vld_rdy_fifo.sv - queue-model self-checking bench for vld_rdy_fifo
module tb_vld_rdy_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int AW = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vld_i = 1'b0;
  logic          rdy_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          rdy_o, vld_o, full_o, empty_o;
  logic [DW-1:0] data_o;
  logic [AW:0]   cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] outs[$];

  vld_rdy_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .vld_i(vld_i), .rdy_o(rdy_o), .data_i(data_i),
    .vld_o(vld_o), .rdy_i(rdy_i), .data_o(data_o),
    .cnt_o(cnt_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_bypass();
`ifdef VLD_RDY_FIFO_BYPASS_EN
    return (q.size() == 0) && vld_i;
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: occupancy is the queue length; the head is q[0].
  always @(posedge clk or negedge rst_n) begin
    int sz;
    if (!rst_n) begin
      q.delete();
    end else begin
      sz = q.size();
      if (m_bypass() && rdy_i) begin
        outs.push_back(data_i);
      end else begin
        if (sz > 0 && rdy_i) outs.push_back(q.pop_front());
        if (vld_i && sz < DEPTH) q.push_back(data_i);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("vld_o", vld_o, (q.size() > 0) || m_bypass());
      check("rdy_o", rdy_o, q.size() < DEPTH);
      check("cnt_o", cnt_o, q.size());
      check("full_o", full_o, q.size() == DEPTH);
      check("empty_o", empty_o, q.size() == 0);
      if (q.size() > 0) check("data_o", data_o, q[0]);
      else if (m_bypass()) check("data_o_byp", data_o, data_i);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_vld_o"}, vld_o, 0);
    check({tag, "_rdy_o"}, rdy_o, 1);
    check({tag, "_cnt_o"}, cnt_o, 0);
    check({tag, "_empty_o"}, empty_o, 1);
    check({tag, "_full_o"}, full_o, 0);
    check({tag, "_data_o"}, data_o, 0);
  endtask

  task automatic drain(input int n);
    vld_i = 1'b0;
    rdy_i = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    logic [DW-1:0] exp_seq[$];

    #12;
    check_reset_vals("rst");
    rst_n = 1'b1;
    step();
    check_reset_vals("post_rst");

    // Fill to full with downstream stalled, then offer a fifth word.
    rdy_i = 1'b0;
    vld_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      data_i = DW'(i * 'h11);
      step();
    end
    check("fill_cnt", cnt_o, 4);
    check("fill_full", full_o, 1);
    check("fill_rdy", rdy_o, 0);
    data_i = 'h55;
    step();
    check("refused_cnt", cnt_o, 4);

    // Pop while full: push refused that cycle, accepted the next.
    outs.delete();
    rdy_i = 1'b1;
    step();
    check("pop_full_cnt", cnt_o, 3);
    rdy_i = 1'b0;
    step();
    check("accept55_cnt", cnt_o, 4);
    drain(6);
    exp_seq = '{'h11, 'h22, 'h33, 'h44, 'h55};
    check("order_len", outs.size(), 5);
    for (int i = 0; i < 5 && i < outs.size(); i++) check("order", outs[i], exp_seq[i]);

    // One pre-load then streaming; occupancy must stay at one across wraps.
    outs.delete();
    vld_i = 1'b1;
    rdy_i = 1'b0;
    data_i = 'hF0;
    step();
    rdy_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_i = DW'(i);
      step();
      check("stream_cnt", cnt_o, 1);
    end
    drain(2);
    check("stream_len", outs.size(), 11);
    for (int i = 0; i < 11 && i < outs.size(); i++)
      check("stream_seq", outs[i], (i == 0) ? DW'('hF0) : DW'(i - 1));

    // Async reset with three entries held.
    vld_i = 1'b1;
    rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      data_i = DW'('hC0 + i);
      step();
    end
    check("pre_rst_cnt", cnt_o, 3);
    vld_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    step();
    rst_n = 1'b1;
    outs.delete();
    vld_i = 1'b1;
    data_i = 'hAB;
    step();
    drain(2);
    check("after_rst_len", outs.size(), 1);
    if (outs.size() > 0) check("after_rst_first", outs[0], 'hAB);

    // Empty FIFO, word offered with downstream ready.
    outs.delete();
    vld_i = 1'b1;
    rdy_i = 1'b1;
    data_i = 'h5A;
    #1;
`ifdef VLD_RDY_FIFO_BYPASS_EN
    check("byp_vld", vld_o, 1);
    check("byp_data", data_o, 'h5A);
    check("byp_cnt", cnt_o, 0);
    step();
    vld_i = 1'b0;
    #1;
    check("byp_after_cnt", cnt_o, 0);
    check("byp_after_vld", vld_o, 0);
`else
    check("nobyp_vld0", vld_o, 0);
    step();
    vld_i = 1'b0;
    #1;
    check("nobyp_vld1", vld_o, 1);
    check("nobyp_data", data_o, 'h5A);
    step();
`endif
    drain(1);
    check("x5a_len", outs.size(), 1);
    if (outs.size() > 0) check("x5a_word", outs[0], 'h5A);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 2000; i++) begin
      vld_i = ($urandom_range(0, 99) < 60);
      rdy_i = ($urandom_range(0, 99) < 50);
      data_i = $urandom;
      step();
    end
    drain(DEPTH + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
